// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default
// latencies and the counter width. The controller imports this too.
package mdu_pkg;

    typedef logic [3:0] mdu_op_t;

    localparam mdu_op_t MDU_NONE = 4'd0;
    localparam mdu_op_t MULT     = 4'd1;
    localparam mdu_op_t MULTU    = 4'd2;
    localparam mdu_op_t DIV      = 4'd3;
    localparam mdu_op_t DIVU     = 4'd4;
    localparam mdu_op_t MTHI     = 4'd5;
    localparam mdu_op_t MTLO     = 4'd6;
    localparam mdu_op_t MFHI     = 4'd7;
    localparam mdu_op_t MFLO     = 4'd8;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;
    localparam int MDU_CNT_W      = 16;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_mul_op(input mdu_op_t op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic is_div_op(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage connection between the controller/datapath and the MDU.
//
// Handshake: there is no valid/ready pair. start is a one-cycle launch
// pulse honoured only when busy is low and mdu_op is mult/multu/div/divu;
// we_hilo writes HI or LO only when busy is low and start is low. The
// controller is expected to stall while start or busy is high; anything
// it issues during busy is dropped, never queued.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    mdu_op_t     mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we_hilo;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    modport master (
        output start, mdu_op, a, b, we_hilo,
        input  busy, hi, lo, rdata
    );

    modport slave (
        input  start, mdu_op, a, b, we_hilo,
        output busy, hi, lo, rdata
    );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// The result is computed at launch into a pending register; a down-counter
// then models the latency and commits the result when it reaches one.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    logic [MDU_CNT_W-1:0] counter;
    logic [31:0]          hi_q;
    logic [31:0]          lo_q;
    logic [63:0]          pending;
    logic                 pending_ok;

    logic        launch;
    logic [63:0] res;
    logic        res_ok;
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [31:0] div_b;
    logic        div_ovf;

    assign launch = bus.start && (counter == '0)
                    && (is_mul_op(bus.mdu_op) || is_div_op(bus.mdu_op));

    // Result the launching op will commit; res_ok clear means keep HI/LO.
    always_comb begin
        a_sx    = {{32{bus.a[31]}}, bus.a};
        b_sx    = {{32{bus.b[31]}}, bus.b};
        // Substitute divisor keeps the unused divide path free of x / 0.
        div_b   = (bus.b == 32'd0) ? 32'd1 : bus.b;
        div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
        res     = 64'd0;
        res_ok  = 1'b1;
        case (bus.mdu_op)
            MULT:  res = a_sx * b_sx;
            MULTU: res = {32'd0, bus.a} * {32'd0, bus.b};
            DIV: begin
                if (bus.b == 32'd0) begin
                    res_ok = 1'b0;
                end else if (div_ovf) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    res = {32'($signed(bus.a) % $signed(div_b)),
                           32'($signed(bus.a) / $signed(div_b))};
                end
            end
            DIVU: begin
                if (bus.b == 32'd0) begin
                    res_ok = 1'b0;
                end else begin
                    res = {bus.a % div_b, bus.a / div_b};
                end
            end
            default: res = 64'd0;
        endcase
    end

    // Launch, count down, commit on the last busy cycle, or take mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pending    <= 64'd0;
            pending_ok <= 1'b0;
        end else if (launch) begin
            pending    <= res;
            pending_ok <= res_ok;
            counter    <= is_mul_op(bus.mdu_op) ? MDU_CNT_W'(MUL_CYCLES)
                                                : MDU_CNT_W'(DIV_CYCLES);
        end else if (counter != '0) begin
            counter <= counter - 1'b1;
            if ((counter == MDU_CNT_W'(1)) && pending_ok) begin
                hi_q <= pending[63:32];
                lo_q <= pending[31:0];
            end
        end else if (bus.we_hilo && !bus.start) begin
            if (bus.mdu_op == MTHI) hi_q <= bus.a;
            if (bus.mdu_op == MTLO) lo_q <= bus.a;
        end
    end

    assign bus.busy = (counter != '0);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // mfhi/mflo read the architectural registers directly, no bypass.
    always_comb begin
        bus.rdata = 32'd0;
        if (bus.mdu_op == MFHI) bus.rdata = hi_q;
        if (bus.mdu_op == MFLO) bus.rdata = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for the MDU. Each launch pushes {busy length, HI, LO};
// the monitor pops one entry each time busy falls and compares.
module tb_mdu;
    import mdu_pkg::*;

    localparam int W = 72;

    logic clk = 1'b0;
    logic reset;

    mdu_if bus ();

    mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // scoreboard monitor: busy falling marks completion of one operation
    int busy_len = 0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (bus.busy === 1'b1) begin
            busy_len++;
        end else if (busy_len != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                if (e[71:64] != 8'd0) chk("busy_len", 64'(busy_len), 64'(e[71:64]));
                chk("hi_commit", 64'(bus.hi), 64'(e[63:32]));
                chk("lo_commit", 64'(bus.lo), 64'(e[31:0]));
            end
            busy_len = 0;
        end
    end

    // driver tasks
    task automatic pulse(input mdu_op_t op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = av;
        bus.b      = bv;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = MDU_NONE;
        bus.a      = $urandom;
        bus.b      = $urandom;
    endtask

    task automatic launch(input mdu_op_t op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [7:0] len, input logic [31:0] ehi, input logic [31:0] elo);
        exp_q.push_back({len, ehi, elo});
        pulse(op, av, bv);
    endtask

    task automatic write_hilo(input mdu_op_t op, input logic [31:0] av);
        @(negedge clk);
        bus.we_hilo = 1'b1;
        bus.mdu_op  = op;
        bus.a       = av;
        @(negedge clk);
        bus.we_hilo = 1'b0;
        bus.mdu_op  = MDU_NONE;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && bus.busy === 1'b0) return;
        end
        chk("idle_timeout_queue_size", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic read_reg(input string name, input mdu_op_t op, input logic [31:0] req);
        bus.mdu_op = op;
        #1;
        chk(name, 64'(bus.rdata), 64'(req));
        bus.mdu_op = MDU_NONE;
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mdu_op  = MDU_NONE;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.we_hilo = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        read_reg("reset_rdata_mfhi", MFHI, 32'd0);

        // multiply, signed then unsigned; mflo during busy sees old LO
        launch(MULT, 32'hFFFF_FFFF, 32'd2, 8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        read_reg("mflo_while_busy", MFLO, 32'd0);
        wait_idle();
        read_reg("mfhi_after_mult", MFHI, 32'hFFFF_FFFF);
        launch(MULTU, 32'hFFFF_FFFF, 32'd2, 8'd5, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_idle();

        // divide, signed/unsigned and signed overflow
        launch(DIV, 32'hFFFF_FFF9, 32'd2, 8'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_idle();
        launch(DIVU, 32'd7, 32'd2, 8'd10, 32'd1, 32'd3);
        wait_idle();
        launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 8'd10, 32'd0, 32'h8000_0000);
        wait_idle();

        // divide by zero keeps preloaded HI/LO
        write_hilo(MTHI, 32'h11);
        write_hilo(MTLO, 32'h22);
        #1;
        chk("mthi_preload", 64'(bus.hi), 64'h11);
        chk("mtlo_preload", 64'(bus.lo), 64'h22);
        launch(DIV, 32'd5, 32'd0, 8'd10, 32'h11, 32'h22);
        wait_idle();
        launch(DIVU, 32'd9, 32'd0, 8'd10, 32'h11, 32'h22);
        wait_idle();

        // start while busy is dropped
        launch(MULT, 32'd3, 32'd4, 8'd5, 32'd0, 32'd12);
        @(negedge clk);
        pulse(DIV, 32'd100, 32'd7);
        wait_idle();

        // mtlo during busy is ignored, mthi after busy lands
        launch(MULT, 32'd6, 32'd7, 8'd5, 32'd0, 32'd42);
        write_hilo(MTLO, 32'hDEAD);
        wait_idle();
        chk("lo_after_ignored_mtlo", 64'(bus.lo), 64'd42);
        write_hilo(MTHI, 32'hBEEF);
        #1;
        chk("hi_after_mthi", 64'(bus.hi), 64'hBEEF);
        read_reg("rdata_mfhi", MFHI, 32'hBEEF);
        read_reg("rdata_mflo", MFLO, 32'd42);

        // start with a non-arithmetic op wins over we_hilo and does nothing
        @(negedge clk);
        bus.start   = 1'b1;
        bus.we_hilo = 1'b1;
        bus.mdu_op  = MTHI;
        bus.a       = 32'h5555;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.we_hilo = 1'b0;
        bus.mdu_op  = MDU_NONE;
        #1;
        chk("start_nonarith_busy", 64'(bus.busy), 64'd0);
        chk("start_beats_we_hilo", 64'(bus.hi), 64'hBEEF);

        // reset mid-divide aborts without a late commit
        launch(DIV, 32'd100, 32'd3, 8'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        repeat (15) @(negedge clk);
        #1;
        chk("no_late_commit_hi", 64'(bus.hi), 64'd0);
        chk("no_late_commit_lo", 64'(bus.lo), 64'd0);
        chk("no_late_busy", 64'(bus.busy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit that sits beside the ALU in the execute stage.
- Consumes the same GRF operands (rs → a, rt → b) and a decoded op from the controller.
- Holds the architectural HI/LO registers and serves mult, multu, div, divu, mthi, mtlo, mfhi and mflo.
- Multi-cycle: raises busy while computing. The controller stalls any later MDU instruction while busy or start is high.

Parameters:
MUL_CYCLES, 5, cycles busy is held for mult/multu (must be ≥1)
DIV_CYCLES, 10, cycles busy is held for div/divu (must be ≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears HI, LO, counter and busy
start  input  1  one-cycle pulse: launch the operation named by mdu_op (mult/multu/div/divu only)
mdu_op  input  4  operation code (package constants)
a  input  32  operand A (GRF RD1)
b  input  32  operand B (GRF RD2)
we_hilo  input  1  write strobe for mthi/mtlo; op selected by mdu_op
busy  output  1  computation in progress
hi  output  32  current HI register
lo  output  32  current LO register
rdata  output  32  combinational: hi when mdu_op==MFHI, lo when MFLO, else 32'h0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: hi=0, lo=0, busy=0, internal counter=0, pending result=0. Reset wins over every other input in the same cycle. Reset mid-operation aborts it; HI/LO are not updated.
- Launch: start sampled high at edge t with busy=0:
  - latch result: mult → signed 64-bit a*b; multu → unsigned a*b; div → LO=a/b, HI=a%b (signed, quotient truncates toward zero, remainder takes sign of a); divu → unsigned.
  - load counter with MUL_CYCLES or DIV_CYCLES.
- Busy: busy = (counter != 0). It is high for exactly N cycles after edge t.
- Commit: at the edge where counter==1, HI/LO take the pending result and counter→0. New values are visible the cycle busy falls.
- Division by zero (b==0, div or divu): the busy timing is identical, but HI/LO keep their old values.
- Signed overflow div (a=0x80000000, b=0xFFFFFFFF): LO=0x80000000, HI=0.
- start while busy=1: ignored entirely; there is no queue. The controller guarantees this does not happen, and the bench checks it is harmless.
- start with a non-arithmetic mdu_op: ignored.
- mthi/mtlo: we_hilo high at an edge with busy=0 and start=0 → hi←a (MTHI) or lo←a (MTLO), visible next cycle.
  - Ignored while busy.
  - If start and we_hilo are high together, start wins.
- hi/lo outputs are the registers themselves, with no bypass of an in-flight result.
- rdata is combinational. mfhi/mflo while busy return the old registers; the controller stalls such reads.
- Widths: products are full 64-bit, HI=[63:32], LO=[31:0]. Operands are latched at launch, so a/b may change during busy.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op constants: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Default latency constants.
- The controller imports the same package to drive mdu_op and to form stall = mdu-class instr & (start | busy).
- No sub-module needed. Arithmetic uses behavioral * / % into a pending register, then a down-counter provides the timing.

Test Plan:
- mult: a=0xFFFFFFFF, b=2 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu → hi=0x00000001, lo=0xFFFFFFFE.
- div: a=0xFFFFFFF9 (-7), b=2 → busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Same operands with divu, a=7 → lo=3, hi=1.
- div by zero: preload hi=0x11, lo=0x22 via mthi/mtlo; div a=5, b=0 → busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Start while busy: start mult 3*4, pulse start with div 100/7 two cycles later → ignored; busy falls after 5 cycles; lo=12, hi=0.
- mtlo during busy: mult 6*7 in flight, mtlo a=0xDEAD → ignored, lo=42 after commit. mthi a=0xBEEF after busy → hi=0xBEEF next cycle; rdata with MFHI=0xBEEF.
- Reset mid-divide: div 100/3, assert reset at cycle 4 → hi=lo=0 and busy=0 the next cycle; no late commit appears afterwards.
